cpu_control_seq: RTL and testbench

//  Parametrised multicycle control sequencer for the accumulator CPU.

---
 rtl/cpu_control_seq_if.sv | 30 +++
 rtl/cpu_control_seq.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_control_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_seq_if.sv
// Memory-side handshake bundle for the control sequencer. The instruction and data
// request/ack pairs travel together; the master is the CPU side.
interface cpu_control_seq_if #(
  parameter int OPCODE_W = 3
) ();
  logic                mem_ins_en;
  logic                ins_ack;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_da_en;
  logic                mem_da_we;
  logic                da_ack;

  modport master (
    output mem_ins_en,
    output mem_da_en,
    output mem_da_we,
    input  ins_ack,
    input  opcode,
    input  da_ack
  );

  modport slave (
    input  mem_ins_en,
    input  mem_da_en,
    input  mem_da_we,
    output ins_ack,
    output opcode,
    output da_ack
  );
endinterface

// File: rtl/cpu_control_seq.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer for the accumulator CPU. It has ack-timed
// memory accesses, a resumable HALT, a sticky illegal-opcode flag and bus-error trap.
module cpu_control_seq #(
  parameter int OPCODE_W = 3,
  parameter int WAIT_W   = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_control_seq_if.master    mem,
  input  logic                 is_zero,
  input  logic                 resume,
  output logic                 acc_load,
  output logic                 acc_sel,
  output logic                 pc_en,
  output logic                 pc_skip,
  output logic                 pc_load,
  output logic                 jmp,
  output logic                 halt,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     retired,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // The last permitted unacked cycle: a request is held for at most WAIT_MAX cycles.
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX - 1);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;

  logic                legal_s;
  logic [2:0]          op_s;
  logic                mem_op_s;
  logic                ins_en_s, da_en_s, da_we_s;
  logic                acc_load_s, acc_sel_s, pc_en_s, pc_skip_s, pc_load_s, jmp_s, halt_s;

  assign legal_s  = ((ir_q >> 3'd3) == {OPCODE_W{1'b0}});
  assign op_s     = ir_q[2:0];
  assign mem_op_s = legal_s && (op_s >= OP_ADD) && (op_s <= OP_STO);

  // State and architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= {OPCODE_W{1'b0}};
      wait_q    <= {WAIT_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic, including the per-access timeout.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (mem.ins_ack) begin
          ir_d    = mem.opcode;
          wait_d  = {WAIT_W{1'b0}};
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LIM) begin
          bus_err_d = 1'b1;
          wait_d    = {WAIT_W{1'b0}};
          state_d   = S_HALTED;
        end else begin
          wait_d = wait_q + WAIT_W'(1'b1);
        end
      end
      S_DECODE: begin
        if (!legal_s) begin
          illegal_d = 1'b1;
          state_d   = S_WB;
        end else if (op_s == OP_HLT) begin
          state_d = S_HALTED;
        end else begin
          wait_d  = {WAIT_W{1'b0}};
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!mem_op_s) begin
          state_d = S_WB;
        end else if (mem.da_ack) begin
          wait_d  = {WAIT_W{1'b0}};
          state_d = S_WB;
        end else if (wait_q == WAIT_LIM) begin
          bus_err_d = 1'b1;
          wait_d    = {WAIT_W{1'b0}};
          state_d   = S_HALTED;
        end else begin
          wait_d = wait_q + WAIT_W'(1'b1);
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1'b1);
        wait_d    = {WAIT_W{1'b0}};
        state_d   = S_FETCH;
      end
      S_HALTED: begin
        if (resume && !bus_err_q) begin
          ir_d    = {OPCODE_W{1'b0}};
          state_d = S_WB;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Moore strobes; everything is forced low while reset is held.
  always_comb begin
    ins_en_s   = 1'b0;
    da_en_s    = 1'b0;
    da_we_s    = 1'b0;
    acc_load_s = 1'b0;
    acc_sel_s  = 1'b0;
    pc_en_s    = 1'b0;
    pc_skip_s  = 1'b0;
    pc_load_s  = 1'b0;
    jmp_s      = 1'b0;
    halt_s     = 1'b0;
    if (rst) begin
      ins_en_s = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: ins_en_s = 1'b1;
        S_EXEC: begin
          da_en_s = mem_op_s;
          da_we_s = legal_s && (op_s == OP_STO);
          jmp_s   = legal_s && (op_s == OP_JMP);
        end
        S_WB: begin
          if (!legal_s) begin
            pc_en_s = 1'b1;
          end else begin
            case (op_s)
              OP_ADD, OP_AND, OP_XOR: begin
                acc_load_s = 1'b1;
                pc_en_s    = 1'b1;
              end
              OP_LDA: begin
                acc_load_s = 1'b1;
                acc_sel_s  = 1'b1;
                pc_en_s    = 1'b1;
              end
              OP_JMP: begin
                pc_load_s = 1'b1;
                jmp_s     = 1'b1;
              end
              OP_SKZ: begin
                pc_en_s   = 1'b1;
                pc_skip_s = is_zero;
              end
              default: pc_en_s = 1'b1;
            endcase
          end
        end
        S_HALTED: halt_s = 1'b1;
        default:  halt_s = 1'b0;
      endcase
    end
  end

  assign mem.mem_ins_en = ins_en_s;
  assign mem.mem_da_en  = da_en_s;
  assign mem.mem_da_we  = da_we_s;
  assign acc_load       = acc_load_s;
  assign acc_sel        = acc_sel_s;
  assign pc_en          = pc_en_s;
  assign pc_skip        = pc_skip_s;
  assign pc_load        = pc_load_s;
  assign jmp            = jmp_s;
  assign halt           = halt_s;
  assign illegal        = illegal_q;
  assign bus_err        = bus_err_q;
  assign retired        = retired_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_cpu_control_seq.sv
// Self-checking bench for cpu_control_seq: directed scenarios plus a random instruction
// stream, judged against per-phase expectations and an abstract PC/retire model.
module tb_cpu_control_seq;
  localparam int OPW  = 4;
  localparam int WMAX = 15;
  localparam int CW   = 16;

  localparam logic [9:0] B_INS = 10'b10_0000_0000;
  localparam logic [9:0] B_DA  = 10'b01_0000_0000;
  localparam logic [9:0] B_WE  = 10'b00_1000_0000;
  localparam logic [9:0] B_LD  = 10'b00_0100_0000;
  localparam logic [9:0] B_SEL = 10'b00_0010_0000;
  localparam logic [9:0] B_PE  = 10'b00_0001_0000;
  localparam logic [9:0] B_SK  = 10'b00_0000_1000;
  localparam logic [9:0] B_PL  = 10'b00_0000_0100;
  localparam logic [9:0] B_JP  = 10'b00_0000_0010;
  localparam logic [9:0] B_HL  = 10'b00_0000_0001;
  localparam logic [9:0] B_NONE = 10'b00_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic is_zero = 1'b0;
  logic resume = 1'b0;
  logic acc_load, acc_sel, pc_en, pc_skip, pc_load, jmp, halt, illegal, bus_err;
  logic [CW-1:0] retired;
  logic [2:0]    state_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_retired = 0;
  logic exp_illegal = 1'b0;
  logic [15:0] tb_pc;
  logic [15:0] exp_pc = 16'd0;
  logic [15:0] jmp_target = 16'd0;

  cpu_control_seq_if #(.OPCODE_W(OPW)) mem_if ();

  cpu_control_seq #(.OPCODE_W(OPW), .WAIT_W(4), .WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem(mem_if), .is_zero(is_zero), .resume(resume),
    .acc_load(acc_load), .acc_sel(acc_sel), .pc_en(pc_en), .pc_skip(pc_skip),
    .pc_load(pc_load), .jmp(jmp), .halt(halt), .illegal(illegal), .bus_err(bus_err),
    .retired(retired), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Simple PC datapath driven by the sequencer strobes.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_pc <= 16'd0;
    else if (pc_load) tb_pc <= jmp_target;
    else if (pc_en) tb_pc <= tb_pc + (pc_skip ? 16'd2 : 16'd1);
  end

  wire [12:0] obs_v = {mem_if.mem_ins_en, mem_if.mem_da_en, mem_if.mem_da_we, acc_load, acc_sel,
                       pc_en, pc_skip, pc_load, jmp, halt, state_o};

  function automatic logic [12:0] vec(input logic [2:0] st, input logic [9:0] b);
    return {b, st};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick(input string tag, input logic [12:0] ev);
    #1;
    chk(tag, 32'(obs_v), 32'(ev));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input int iw, input int dw,
                           input int hw, input logic [15:0] target);
    logic legal;
    logic [9:0] wbm;
    legal = (op < 4'd8);
    is_zero = z;
    jmp_target = target;
    for (int k = 0; k <= iw; k++) begin
      mem_if.ins_ack = (k == iw);
      mem_if.opcode  = (k == iw) ? op : 4'($urandom);
      tick("fetch", vec(3'd0, B_INS));
    end
    mem_if.ins_ack = 1'b0;
    mem_if.opcode  = 4'($urandom);
    tick("decode", vec(3'd1, B_NONE));
    if (!legal) exp_illegal = 1'b1;
    if (legal && op == 4'd0) begin
      mem_if.ins_ack = 1'b1;
      mem_if.da_ack  = 1'b1;
      for (int h = 0; h < hw; h++) tick("halted", vec(3'd4, B_HL));
      mem_if.ins_ack = 1'b0;
      mem_if.da_ack  = 1'b0;
      resume = 1'b1;
      tick("halted_resume", vec(3'd4, B_HL));
      resume = 1'b0;
    end else if (legal) begin
      if (op >= 4'd2 && op <= 4'd6) begin
        for (int k = 0; k <= dw; k++) begin
          mem_if.da_ack = (k == dw);
          tick("exec_mem", vec(3'd2, B_DA | ((op == 4'd6) ? B_WE : B_NONE)));
        end
        mem_if.da_ack = 1'b0;
      end else begin
        tick("exec_1c", vec(3'd2, (op == 4'd7) ? B_JP : B_NONE));
      end
    end
    if (!legal) wbm = B_PE;
    else if (op == 4'd1) wbm = B_PE | (z ? B_SK : B_NONE);
    else if (op >= 4'd2 && op <= 4'd4) wbm = B_LD | B_PE;
    else if (op == 4'd5) wbm = B_LD | B_SEL | B_PE;
    else if (op == 4'd7) wbm = B_PL | B_JP;
    else wbm = B_PE;
    tick("wb", vec(3'd3, wbm));
    exp_retired = (exp_retired + 1) % (1 << CW);
    if (legal && op == 4'd7) exp_pc = target;
    else if (legal && op == 4'd1 && z) exp_pc = exp_pc + 16'd2;
    else exp_pc = exp_pc + 16'd1;
    chk("retired", 32'(retired), 32'(exp_retired));
    chk("pc", 32'(tb_pc), 32'(exp_pc));
    chk("flags", {30'd0, illegal, bus_err}, {30'd0, exp_illegal, 1'b0});
  endtask

  task automatic model_reset();
    exp_retired = 0;
    exp_pc = 16'd0;
    exp_illegal = 1'b0;
  endtask

  initial begin
    int c0;
    logic [3:0] rop;
    int riw, rdw;
    mem_if.ins_ack = 1'b0;
    mem_if.da_ack  = 1'b0;
    mem_if.opcode  = 4'd0;
    #2;
    chk("reset_strobes", 32'(obs_v), 32'(vec(3'd0, B_NONE)));
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_flags", {30'd0, illegal, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Zero-wait stream: LDA, ADD, STO, JMP in 16 cycles.
    c0 = cyc;
    run_instr(4'd5, 1'b0, 0, 0, 0, 16'd0);
    run_instr(4'd2, 1'b0, 0, 0, 0, 16'd0);
    run_instr(4'd6, 1'b0, 0, 0, 0, 16'd0);
    run_instr(4'd7, 1'b0, 0, 0, 0, 16'h0040);
    chk("t1_cycles", 32'(cyc - c0), 32'd16);
    chk("t1_retired", 32'(retired), 32'd4);

    // SKZ taken and not taken.
    run_instr(4'd1, 1'b1, 0, 0, 0, 16'd0);
    run_instr(4'd1, 1'b0, 0, 0, 0, 16'd0);

    // STO with a three-cycle data ack delay, and a fetch acked on the limit cycle.
    run_instr(4'd6, 1'b0, 0, 3, 0, 16'd0);
    run_instr(4'd3, 1'b0, WMAX - 1, WMAX - 1, 0, 16'd0);

    // HLT then resume; illegal opcode 9 as NOP.
    run_instr(4'd0, 1'b0, 1, 0, 3, 16'd0);
    run_instr(4'd9, 1'b0, 0, 0, 0, 16'd0);
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);

    // Random stream.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      riw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WMAX - 1) : $urandom_range(0, 2);
      rdw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WMAX - 1) : $urandom_range(0, 2);
      run_instr(rop, 1'($urandom_range(0, 1)), riw, rdw, $urandom_range(1, 3), 16'($urandom));
    end

    // Reset in the middle of a STO data access.
    mem_if.ins_ack = 1'b1;
    mem_if.opcode  = 4'd6;
    tick("t6_fetch", vec(3'd0, B_INS));
    mem_if.ins_ack = 1'b0;
    tick("t6_decode", vec(3'd1, B_NONE));
    #1;
    chk("t6_exec", 32'(obs_v), 32'(vec(3'd2, B_DA | B_WE)));
    rst = 1'b1;
    #1;
    chk("t6_rst_strobes", 32'(obs_v), 32'(vec(3'd0, B_NONE)));
    chk("t6_rst_retired", 32'(retired), 32'd0);
    chk("t6_rst_flags", {30'd0, illegal, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_fetch_after", 32'(obs_v), 32'(vec(3'd0, B_INS)));
    run_instr(4'd4, 1'b0, 0, 0, 0, 16'd0);

    // Instruction fetch never acked: bus error, HALTED, resume ignored.
    for (int k = 0; k < WMAX; k++) begin
      mem_if.ins_ack = 1'b0;
      tick("to_fetch", vec(3'd0, B_INS));
    end
    chk("to_flags", {30'd0, illegal, bus_err}, 32'd1);
    resume = 1'b1;
    tick("to_resume", vec(3'd4, B_HL));
    resume = 1'b0;
    tick("to_stay", vec(3'd4, B_HL));
    tick("to_stay2", vec(3'd4, B_HL));
    chk("to_retired", 32'(retired), 32'(exp_retired));
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    rst = 1'b1;
    #1;
    chk("to_rst_flags", {30'd0, illegal, bus_err}, 32'd0);
    chk("to_rst_strobes", 32'(obs_v), 32'(vec(3'd0, B_NONE)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_instr(4'd5, 1'b0, 0, 1, 0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
